systolic_operand_feeder: RTL and testbench

//  Transmit side of the PE operand interface. Buffers one A tile (N x K) and one B tile (K x N).

---
 rtl/systolic_operand_feeder_pkg.sv | 15 +
 rtl/systolic_operand_feeder_if.sv | 28 ++
 rtl/systolic_operand_feeder_tile_buf.sv | 55 +++++
 rtl/systolic_operand_feeder.sv | 80 ++++++++
 tb/tb_systolic_operand_feeder.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/systolic_operand_feeder_pkg.sv
// Definitions shared between the operand feeder and the PE array.
// The PEs use HOLD_CYCLES and FP_ZERO as well.
package systolic_pkg;
    localparam int DATA_W      = 32;
    localparam int HOLD_CYCLES = 6;
    localparam logic [DATA_W-1:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} feeder_state_e;

    // One spare code above the largest dimension, so that an out-of-range
    // index can be expressed on the write port and then dropped.
    function automatic int idx_width(input int n, input int k);
        return $clog2((n > k ? n : k) + 1);
    endfunction
endpackage

// File: rtl/systolic_operand_feeder_if.sv
// Tile-loader write port and the array-edge outputs of the operand feeder.
interface systolic_operand_feeder_if import systolic_pkg::*; #(
    parameter int N     = 4,
    parameter int K     = 4,
    parameter int IDX_W = idx_width(N, K)
);
    logic                         wr_valid;
    logic                         wr_ready;
    logic                         wr_sel;
    logic [IDX_W-1:0]             wr_row;
    logic [IDX_W-1:0]             wr_col;
    logic [DATA_W-1:0]            wr_data;
    logic                         start;
    logic                         busy;
    logic [N-1:0][DATA_W-1:0]     a_out;
    logic [N-1:0][DATA_W-1:0]     b_out;
    logic                         step_stb;
    logic                         done;

    modport master (
        output wr_valid, wr_sel, wr_row, wr_col, wr_data, start,
        input  wr_ready, busy, a_out, b_out, step_stb, done
    );
    modport slave (
        input  wr_valid, wr_sel, wr_row, wr_col, wr_data, start,
        output wr_ready, busy, a_out, b_out, step_stb, done
    );
endinterface

// File: rtl/systolic_operand_feeder_tile_buf.sv
// A (N x K) and B (K x N) operand buffers with one write port and
// 2N skewed read ports that select the wavefront diagonal for step rd_step.
module operand_tile_buf import systolic_pkg::*; #(
    parameter int N     = 4,
    parameter int K     = 4,
    parameter int IDX_W = idx_width(N, K),
    parameter int S_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [IDX_W-1:0]         wr_row,
    input  logic [IDX_W-1:0]         wr_col,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [S_W-1:0]           rd_step,
    output logic [N-1:0][DATA_W-1:0] a_rd,
    output logic [N-1:0][DATA_W-1:0] b_rd
);
    logic [N-1:0][K-1:0][DATA_W-1:0] a_mem;
    logic [K-1:0][N-1:0][DATA_W-1:0] b_mem;

    // Indices outside the tile match no cell, so such writes fall away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_mem <= '0;
            b_mem <= '0;
        end else if (wr_en) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < K; c++)
                    if (!wr_sel && wr_row == IDX_W'(r) && wr_col == IDX_W'(c))
                        a_mem[r][c] <= wr_data;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < N; c++)
                    if (wr_sel && wr_row == IDX_W'(r) && wr_col == IDX_W'(c))
                        b_mem[r][c] <= wr_data;
        end
    end

    // Lane i sees element k of its row/column when rd_step == i + k.
    always_comb begin
        a_rd = '0;
        b_rd = '0;
        for (int i = 0; i < N; i++) begin
            a_rd[i] = FP_ZERO;
            b_rd[i] = FP_ZERO;
            for (int k = 0; k < K; k++) begin
                if (rd_step == S_W'(i + k)) begin
                    a_rd[i] = a_mem[i][k];
                    b_rd[i] = b_mem[k][i];
                end
            end
        end
    end
endmodule

// File: rtl/systolic_operand_feeder.sv
// Operand feeder: buffers one A/B tile pair and streams it skewed into the
// west/north edges of the PE array, one step per HOLD_CYCLES-cycle period.
module systolic_operand_feeder import systolic_pkg::*; #(
    parameter int N = 4,
    parameter int K = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    systolic_operand_feeder_if.slave   bus
);
    localparam int IDX_W = idx_width(N, K);
    localparam int S     = K + 2 * (N - 1);
    localparam int S_W   = (S > 1) ? $clog2(S) : 1;
    localparam int PH_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    feeder_state_e            state, state_nxt;
    logic [PH_W-1:0]          phase, phase_nxt;
    logic [S_W-1:0]           step, step_nxt;
    logic                     phase_last;
    logic                     wr_en;
    logic [N-1:0][DATA_W-1:0] a_rd, b_rd;

    assign phase_last  = phase == PH_W'(HOLD_CYCLES - 1);
    assign phase_nxt   = phase_last ? '0 : phase + PH_W'(1);
    assign bus.wr_ready = state == IDLE;
    assign bus.busy     = (state == ARM) || (state == RUN);
    assign bus.done     = state == DONE;
    assign wr_en        = bus.wr_valid && bus.wr_ready;

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        case (state)
            IDLE: if (bus.start) state_nxt = ARM;
            ARM:  if (phase_last) begin
                state_nxt = RUN;
                step_nxt  = '0;
            end
            RUN:  if (phase_last) begin
                if (step == S_W'(S - 1)) state_nxt = DONE;
                else                     step_nxt  = step + S_W'(1);
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read ports look at the next step so the edge registers change exactly
    // on the phase wrap and then hold for the whole step.
    operand_tile_buf #(.N(N), .K(K), .IDX_W(IDX_W), .S_W(S_W)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_sel  (bus.wr_sel),
        .wr_row  (bus.wr_row),
        .wr_col  (bus.wr_col),
        .wr_data (bus.wr_data),
        .rd_step (step_nxt),
        .a_rd    (a_rd),
        .b_rd    (b_rd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            phase        <= '0;
            step         <= '0;
            bus.a_out    <= '0;
            bus.b_out    <= '0;
            bus.step_stb <= 1'b0;
        end else begin
            state        <= state_nxt;
            phase        <= phase_nxt;
            step         <= step_nxt;
            bus.a_out    <= (state_nxt == RUN) ? a_rd : '0;
            bus.b_out    <= (state_nxt == RUN) ? b_rd : '0;
            bus.step_stb <= (state_nxt == RUN) && (phase_nxt == '0);
        end
    end
endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for the operand feeder with N=2, K=2, HOLD_CYCLES=6 (S=4).
module tb_systolic_operand_feeder;
    import systolic_pkg::*;

    localparam int IW = idx_width(2, 2);

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    int   ph     = 0;
    logic [63:0] exp_a [4];
    logic [63:0] exp_b [4];

    always #5 clk = ~clk;

    systolic_operand_feeder_if #(.N(2), .K(2)) bus ();

    systolic_operand_feeder #(.N(2), .K(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ph = (ph + 1) % 6;
    endtask

    task automatic wr(input int sel, input int row, input int col, input logic [31:0] data);
        bus.wr_valid = 1'b1;
        bus.wr_sel   = sel[0];
        bus.wr_row   = IW'(row);
        bus.wr_col   = IW'(col);
        bus.wr_data  = data;
        chk("wr_ready_idle", 64'(bus.wr_ready), 64'd1);
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic load_tiles();
        wr(0, 0, 0, 32'h3F800000); wr(0, 0, 1, 32'h40000000);
        wr(0, 1, 0, 32'h40400000); wr(0, 1, 1, 32'h40800000);
        wr(1, 0, 0, 32'h40A00000); wr(1, 0, 1, 32'h40C00000);
        wr(1, 1, 0, 32'h40E00000); wr(1, 1, 1, 32'h41000000);
    endtask

    task automatic set_exp_tile();
        exp_a[0] = {32'h0, 32'h3F800000};        exp_b[0] = {32'h0, 32'h40A00000};
        exp_a[1] = {32'h40400000, 32'h40000000}; exp_b[1] = {32'h40C00000, 32'h40E00000};
        exp_a[2] = {32'h40800000, 32'h0};        exp_b[2] = {32'h41000000, 32'h0};
        exp_a[3] = 64'h0;                        exp_b[3] = 64'h0;
    endtask

    task automatic set_exp_zero();
        for (int s = 0; s < 4; s++) begin
            exp_a[s] = 64'h0;
            exp_b[s] = 64'h0;
        end
    endtask

    // mode 0 plain, 1 write attempt mid-run, 2 start pulse mid-run,
    // 3 write A[0][0]=10.0 in the start cycle
    task automatic run(input int p, input int mode);
        int n_arm;
        for (int i = 0; i < 6 && ph != p; i++) tick();
        bus.start = 1'b1;
        if (mode == 3) begin
            bus.wr_valid = 1'b1; bus.wr_sel = 1'b0;
            bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = 32'h41200000;
        end
        chk("start_idle_ready", 64'(bus.wr_ready), 64'd1);
        tick();
        bus.start = 1'b0; bus.wr_valid = 1'b0;
        n_arm = 6 - ((p + 1) % 6);
        for (int i = 0; i < n_arm; i++) begin
            chk("arm_busy", 64'(bus.busy), 64'd1);
            chk("arm_a", bus.a_out, 64'h0);
            chk("arm_stb", 64'(bus.step_stb), 64'd0);
            tick();
        end
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 6; c++) begin
                if (s == 1 && c == 2 && mode == 1) begin
                    bus.wr_valid = 1'b1; bus.wr_sel = 1'b0;
                    bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = 32'h41200000;
                    chk("run_wr_ready", 64'(bus.wr_ready), 64'd0);
                end
                if (s == 1 && c == 2 && mode == 2) bus.start = 1'b1;
                chk($sformatf("a_s%0d_c%0d", s, c), bus.a_out, exp_a[s]);
                chk($sformatf("b_s%0d_c%0d", s, c), bus.b_out, exp_b[s]);
                chk("run_stb", 64'(bus.step_stb), 64'(c == 0));
                chk("run_busy", 64'(bus.busy), 64'd1);
                chk("run_done", 64'(bus.done), 64'd0);
                tick();
                bus.wr_valid = 1'b0; bus.start = 1'b0;
            end
        end
        chk("done_pulse", 64'(bus.done), 64'd1);
        chk("done_busy", 64'(bus.busy), 64'd0);
        chk("done_a", bus.a_out, 64'h0);
        chk("done_b", bus.b_out, 64'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("post_done", 64'(bus.done), 64'd0);
            chk("post_busy", 64'(bus.busy), 64'd0);
            chk("post_ready", 64'(bus.wr_ready), 64'd1);
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0;
        bus.wr_col = '0; bus.wr_data = '0; bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", bus.a_out, 64'h0);
        chk("rst_b", bus.b_out, 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_stb", 64'(bus.step_stb), 64'd0);
        chk("rst_ready", 64'(bus.wr_ready), 64'd1);
        rst = 1'b1;
        ph = 0;

        load_tiles();
        set_exp_tile();
        run(3, 0);
        run(5, 1);
        run(0, 2);

        exp_a[0] = {32'h0, 32'h41200000};
        run(2, 3);
        wr(0, 0, 0, 32'h3F800000);
        set_exp_tile();

        // reset in the middle of step 2
        for (int i = 0; i < 6 && ph != 0; i++) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5 + 12 + 3) tick();
        chk("pre_rst_a", bus.a_out, exp_a[2]);
        rst = 1'b0;
        #1;
        chk("mid_rst_a", bus.a_out, 64'h0);
        chk("mid_rst_b", bus.b_out, 64'h0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_ready", 64'(bus.wr_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        ph = 0;
        for (int i = 0; i < 30; i++) begin
            chk("no_done_after_rst", 64'(bus.done), 64'd0);
            chk("idle_a_after_rst", bus.a_out, 64'h0);
            tick();
        end

        set_exp_zero();
        run(1, 0);

        wr(0, 2, 0, 32'h41200000);
        wr(1, 2, 1, 32'h41200000);
        wr(0, 0, 2, 32'h41200000);
        run(4, 0);

        load_tiles();
        set_exp_tile();
        run(3, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
